uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8-bit receiver FSM, sitting between the baud-rate generator and the host-side register interface.
- Adds runtime data length of 5..DATA_W bits, an input synchroniser, and 3-sample majority voting.
- Detects and rejects false starts, and detects line break.
- Buffers received frames, each with its error bits, in a show-ahead FIFO and reports overrun.

Parameters:
DATA_W, 8, maximum data bits per frame (>=5).
OVERSAMPLE, 16, bd_tick pulses per bit (even, >=8).
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
bd_tick  in  1  one-clk pulse at OVERSAMPLE x baud.
rx  in  1  serial line, asynchronous, idle high.
rx_enable  in  1  allow new frame starts.
d_num  in  4  data bits per frame; clamped to 5..DATA_W.
s_num  in  1  0 = one stop bit, 1 = two stop bits.
par  in  2  00 none, 01 odd, 10 even, 11 none.
rd_en  in  1  pop FIFO head.
clr_flags  in  1  clear the sticky flags.
d_out  out  DATA_W  FIFO head data, right-aligned, upper bits zero.
par_err  out  1  parity error of the FIFO head frame.
frm_err  out  1  framing error of the FIFO head frame.
fifo_empty  out  1  FIFO empty.
fifo_full  out  1  FIFO full.
rx_done  out  1  one-clk pulse when a frame is pushed.
is_active  out  1  FSM is not in IDLE.
break_flag  out  1  sticky: break detected.
overrun_flag  out  1  sticky: a frame was dropped.

Behaviour:
Reset (async, rst=1):
- FSM enters IDLE; FIFO empties.
- Synchroniser flops are set to 1.
- All outputs are 0, except fifo_empty=1.
- A reset asserted mid-frame discards the frame; no push occurs.

Synchroniser and sampling:
- rx passes through a 2-flop synchroniser (rxs).
- The tick counter s_cnt advances only on bd_tick and is DATA_W-independent, width clog2(OVERSAMPLE).
- The bit value is the majority of rxs at s_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.

States:
- IDLE: when rxs=0 and rx_enable=1, clear s_cnt and go to START. Latch d_num (clamped), s_num and par at this point; later changes are ignored until the next frame.
- START: at the mid-bit vote, a vote of 1 is a false start and returns to IDLE with no push. Otherwise wait out the bit (s_cnt wraps at OVERSAMPLE-1) and go to DATA.
- DATA: shift the voted bits in LSB first. After d_num bits, go to PARITY if parity is enabled, else to STOP.
- PARITY: compare the voted bit with the computed parity. Odd mode means the data bits plus the parity bit contain an odd number of ones; even mode means an even number.
- STOP: vote each stop bit; any 0 sets the frame's frm_err. At the mid-vote of the last stop bit, push {frm_err, par_err, data}, pulse rx_done, and return to IDLE. The FSM does not wait for the end of the stop bit, so it resynchronises on the next frame.
- Break: if all data bits, the parity bit (if present) and the first stop bit are 0, do not push; set break_flag and go to BRKWAIT. BRKWAIT returns to IDLE on the first rxs=1.

rx_enable and flags:
- Deasserting rx_enable mid-frame lets the current frame complete; it only blocks new starts.
- clr_flags clears break_flag and overrun_flag.
- If clr_flags coincides with a setting event, the set wins.

FIFO:
- Show-ahead: d_out, par_err and frm_err are valid whenever fifo_empty=0.
- rd_en pops on the next clk edge; rd_en while empty is ignored.
- A push is visible the clk after rx_done (fifo_empty falls then).
- Push while full without rd_en: the frame is dropped, the FIFO is unchanged, and overrun_flag is set.
- Push while full with rd_en in the same cycle: both operations happen and there is no overrun.
- Pointers wrap modulo FIFO_DEPTH, with an extra MSB for full/empty detection.

Decomposition:
- Package uart_pkg: parity-mode constants PAR_NONE, PAR_ODD, PAR_EVEN; FSM state encodings IDLE, START, DATA, PARITY, STOP, BRKWAIT; clog2 function.
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO, parameters WIDTH and DEPTH, ports clk, rst, wr_en, wr_data, rd_en, rd_data, empty, full.
- The FSM, synchroniser and voter stay in uart_rx_param.

Test Plan:
All cases use defaults with bd_tick every 4th clk.
1. 8N1 frame of 0xA5 -> rx_done pulses once; d_out=0xA5; par_err=0; frm_err=0; fifo_empty=0 until rd_en.
2. d_num=7, even parity, s_num=1, data 0x41 with the parity bit inverted -> d_out=0x41, par_err=1, frm_err=0. Repeat with correct parity -> par_err=0.
3. rx low for 4 ticks, then high -> no push; is_active returns to 0 within 1 bit time; fifo_empty stays 1.
4. 8N1 frame of 0x3C with stop bit 0 -> d_out=0x3C, frm_err=1. Separately, rx held low for 2 frame times -> break_flag=1, no push, FSM back in IDLE after rx returns high.
5. Five back-to-back 8N1 frames 0x01..0x05 with no reads -> fifo_full=1, overrun_flag=1. Reads return 0x01..0x04 in order; clr_flags clears overrun_flag.
6. rst pulsed mid-DATA, then a clean 0x5A frame -> 0x5A is the only FIFO entry and all flags are 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
// Holds the parity-mode codes, the receiver FSM state encoding and a
// constant-evaluable clog2 used to size counters and FIFO pointers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    BRKWAIT = 3'd5
  } rx_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO.
//   clk, rst        : clock, async active-high reset
//   wr_en, wr_data  : push request; dropped when full unless a pop happens
//                     in the same cycle
//   rd_en           : pop head on next edge; ignored while empty
//   rd_data         : head entry, zero while empty
//   empty, full     : status
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with input synchroniser, 3-sample majority
// vote, false-start rejection, break detection and a show-ahead FIFO.
//   clk, rst          : clock, async active-high reset
//   bd_tick           : OVERSAMPLE x baud strobe
//   rx                : async serial input (idle high)
//   rx_enable         : allow new frame starts
//   d_num/s_num/par   : frame format, latched at start detection
//   rd_en, clr_flags  : FIFO pop, sticky flag clear
//   d_out/par_err/frm_err : FIFO head frame
//   fifo_empty/full, rx_done, is_active, break_flag, overrun_flag : status
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              bd_tick,
  input  logic              rx,
  input  logic              rx_enable,
  input  logic [3:0]        d_num,
  input  logic              s_num,
  input  logic [1:0]        par,
  input  logic              rd_en,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] d_out,
  output logic              par_err,
  output logic              frm_err,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              rx_done,
  output logic              is_active,
  output logic              break_flag,
  output logic              overrun_flag
);

  localparam int SW = clog2(OVERSAMPLE);
  localparam int BW = clog2(DATA_W + 1);
  localparam int FW = DATA_W + 2;

  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

  // Two-flop synchroniser, idle-high so reset does not look like a start.
  logic [1:0] sync_q, sync_d;
  logic       rxs;

  always_comb sync_d = {sync_q[0], rx};
  assign rxs = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= sync_d;
  end

  rx_state_e         state_q;
  logic [SW-1:0]     s_cnt_q;
  logic              s0_q, s1_q;
  logic [BW-1:0]     bit_cnt_q, dlen_q;
  logic              stop_cnt_q, two_stop_q;
  logic [1:0]        par_q;
  logic [DATA_W-1:0] data_q;
  logic              par_acc_q, any_one_q, frm_q, perr_q;
  logic              rx_done_q, break_q, overrun_q;
  logic [FW-1:0]     frame_q, fifo_rd;

  logic              vote, tick_v, tick_end, par_en;
  logic [BW-1:0]     d_clamp;
  logic [DATA_W-1:0] aligned;

  always_comb begin
    if (d_num < 4'd5)                d_clamp = BW'(5);
    else if (int'(d_num) > DATA_W)   d_clamp = BW'(DATA_W);
    else                             d_clamp = BW'(d_num);
  end

  // Third sample is taken live, so the vote resolves on the S_V2 tick.
  assign vote     = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
  assign tick_v   = bd_tick && (s_cnt_q == S_V2);
  assign tick_end = bd_tick && (s_cnt_q == S_LAST);
  assign par_en   = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
  // Bits were shifted in from the MSB; move the dlen received bits down.
  assign aligned  = data_q >> (BW'(DATA_W) - dlen_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      s_cnt_q    <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      bit_cnt_q  <= '0;
      dlen_q     <= BW'(DATA_W);
      stop_cnt_q <= 1'b0;
      two_stop_q <= 1'b0;
      par_q      <= PAR_NONE;
      data_q     <= '0;
      par_acc_q  <= 1'b0;
      any_one_q  <= 1'b0;
      frm_q      <= 1'b0;
      perr_q     <= 1'b0;
      rx_done_q  <= 1'b0;
      frame_q    <= '0;
      break_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;

      // Clear first so that a set later in this block takes priority.
      if (clr_flags) begin
        break_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (rx_done_q && fifo_full && !rd_en) overrun_q <= 1'b1;

      if (bd_tick && state_q != IDLE) begin
        s_cnt_q <= (s_cnt_q == S_LAST) ? '0 : s_cnt_q + 1'b1;
        if (s_cnt_q == S_V0) s0_q <= rxs;
        if (s_cnt_q == S_V1) s1_q <= rxs;
      end

      case (state_q)
        IDLE: begin
          if (!rxs && rx_enable) begin
            state_q    <= START;
            s_cnt_q    <= '0;
            dlen_q     <= d_clamp;
            two_stop_q <= s_num;
            par_q      <= par;
            data_q     <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_acc_q  <= 1'b0;
            any_one_q  <= 1'b0;
            frm_q      <= 1'b0;
            perr_q     <= 1'b0;
          end
        end
        START: begin
          if (tick_v && vote) state_q <= IDLE;
          else if (tick_end)  state_q <= DATA;
        end
        DATA: begin
          if (tick_v) begin
            data_q    <= {vote, data_q[DATA_W-1:1]};
            par_acc_q <= par_acc_q ^ vote;
            any_one_q <= any_one_q | vote;
          end
          if (tick_end) begin
            if (bit_cnt_q == dlen_q - 1'b1) state_q <= par_en ? PARITY : STOP;
            else                            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_v) begin
            perr_q    <= (par_q == PAR_ODD) ? !(par_acc_q ^ vote) : (par_acc_q ^ vote);
            any_one_q <= any_one_q | vote;
          end
          if (tick_end) state_q <= STOP;
        end
        STOP: begin
          if (tick_v) begin
            if (!vote && !stop_cnt_q && !any_one_q) begin
              break_q <= 1'b1;
              state_q <= BRKWAIT;
            end else if (stop_cnt_q == two_stop_q) begin
              // Push at mid-stop so the next start edge is never missed.
              frame_q   <= {frm_q | !vote, perr_q, aligned};
              rx_done_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              frm_q <= frm_q | !vote;
            end
          end
          if (tick_end) stop_cnt_q <= 1'b1;
        end
        BRKWAIT: begin
          if (rxs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_done_q),
    .wr_data (frame_q),
    .rd_en   (rd_en),
    .rd_data (fifo_rd),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign d_out        = fifo_rd[DATA_W-1:0];
  assign par_err      = fifo_rd[DATA_W];
  assign frm_err      = fifo_rd[DATA_W+1];
  // rx_done marks every completed frame, including one dropped by overrun.
  assign rx_done      = rx_done_q;
  assign is_active    = (state_q != IDLE);
  assign break_flag   = break_q;
  assign overrun_flag = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int BIT_CLKS = 64;  // 16 ticks/bit, one tick every 4 clk

  logic       clk = 1'b0;
  logic       rst, bd_tick = 1'b0, rx, rx_enable, s_num, rd_en, clr_flags;
  logic [3:0] d_num;
  logic [1:0] par;
  logic [7:0] d_out;
  logic       par_err, frm_err, fifo_empty, fifo_full, rx_done, is_active;
  logic       break_flag, overrun_flag;

  uart_rx_param dut (
    .clk(clk), .rst(rst), .bd_tick(bd_tick), .rx(rx), .rx_enable(rx_enable),
    .d_num(d_num), .s_num(s_num), .par(par), .rd_en(rd_en), .clr_flags(clr_flags),
    .d_out(d_out), .par_err(par_err), .frm_err(frm_err), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .rx_done(rx_done), .is_active(is_active),
    .break_flag(break_flag), .overrun_flag(overrun_flag)
  );

  always #5 clk = ~clk;

  logic [1:0] tdiv = 2'd0;
  always @(negedge clk) begin
    tdiv    = tdiv + 2'd1;
    bd_tick = (tdiv == 2'd0);
  end

  int done_cnt = 0;
  always @(negedge clk) if (rx_done) done_cnt++;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic [1:0] pm,
                            input logic pinv, input int nstop, input logic stopv);
    logic p;
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(d[i]);
    if (pm == 2'b01 || pm == 2'b10) begin
      p = 1'b0;
      for (int i = 0; i < n; i++) p = p ^ d[i];
      if (pm == 2'b01) p = ~p;
      send_bit(p ^ pinv);
    end
    for (int i = 0; i < nstop; i++) send_bit(stopv);
  endtask

  task automatic read_chk(input string tag);
    exp_t e;
    chk({tag, "_pending"}, int'(exp_q.size() > 0), 1);
    chk({tag, "_nonempty"}, int'(fifo_empty), 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_dout"}, int'(d_out), int'(e.d));
      chk({tag, "_par_err"}, int'(par_err), int'(e.pe));
      chk({tag, "_frm_err"}, int'(frm_err), int'(e.fe));
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int base;

  initial begin
    rst = 1'b1; rx = 1'b1; rx_enable = 1'b1; d_num = 4'd8; s_num = 1'b0;
    par = 2'b00; rd_en = 1'b0; clr_flags = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_empty",   int'(fifo_empty), 1);
    chk("rst_full",    int'(fifo_full), 0);
    chk("rst_dout",    int'(d_out), 0);
    chk("rst_active",  int'(is_active), 0);
    chk("rst_break",   int'(break_flag), 0);
    chk("rst_overrun", int'(overrun_flag), 0);
    chk("rst_done",    int'(rx_done), 0);
    rst = 1'b0;
    send_bit(1'b1); send_bit(1'b1);

    // 1: 8N1 0xA5
    base = done_cnt;
    push_exp(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 2'b00, 1'b0, 1, 1'b1);
    send_bit(1'b1);
    chk("t1_done", done_cnt - base, 1);
    chk("t1_idle", int'(is_active), 0);
    read_chk("t1");
    chk("t1_empty_after", int'(fifo_empty), 1);

    // 2: 7E2, bad parity then good parity
    d_num = 4'd7; par = 2'b10; s_num = 1'b1;
    base = done_cnt;
    push_exp(8'h41, 1'b1, 1'b0);
    send_frame(8'h41, 7, 2'b10, 1'b1, 2, 1'b1);
    push_exp(8'h41, 1'b0, 1'b0);
    send_frame(8'h41, 7, 2'b10, 1'b0, 2, 1'b1);
    send_bit(1'b1);
    chk("t2_done", done_cnt - base, 2);
    read_chk("t2a");
    read_chk("t2b");
    d_num = 4'd8; par = 2'b00; s_num = 1'b0;

    // 3: false start, then pop while empty
    base = done_cnt;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    chk("t3_active_on", int'(is_active), 1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    chk("t3_active_off", int'(is_active), 0);
    chk("t3_empty", int'(fifo_empty), 1);
    chk("t3_done", done_cnt - base, 0);
    rd_en = 1'b1; @(negedge clk); rd_en = 1'b0; @(negedge clk);
    chk("t3_pop_empty", int'(fifo_empty), 1);
    chk("t3_pop_full",  int'(fifo_full), 0);

    // 4a: framing error
    base = done_cnt;
    push_exp(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 8, 2'b00, 1'b0, 1, 1'b0);
    send_bit(1'b1); send_bit(1'b1);
    chk("t4a_done", done_cnt - base, 1);
    read_chk("t4a");

    // 4b: break
    base = done_cnt;
    rx = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge clk);
    chk("t4b_brkwait", int'(is_active), 1);
    chk("t4b_break", int'(break_flag), 1);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    chk("t4b_idle", int'(is_active), 0);
    chk("t4b_empty", int'(fifo_empty), 1);
    chk("t4b_done", done_cnt - base, 0);
    pulse_clr();
    chk("t4b_clr", int'(break_flag), 0);

    // 5: overrun
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) push_exp(8'(k), 1'b0, 1'b0);
      send_frame(8'(k), 8, 2'b00, 1'b0, 1, 1'b1);
    end
    send_bit(1'b1);
    chk("t5_full", int'(fifo_full), 1);
    chk("t5_overrun", int'(overrun_flag), 1);
    for (int k = 0; k < 4; k++) read_chk("t5");
    chk("t5_empty", int'(fifo_empty), 1);
    pulse_clr();
    chk("t5_clr", int'(overrun_flag), 0);

    // 6: reset mid-DATA, then clean frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t6_active", int'(is_active), 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_active", int'(is_active), 0);
    chk("t6_rst_empty", int'(fifo_empty), 1);
    rx = 1'b1;
    rst = 1'b0;
    send_bit(1'b1); send_bit(1'b1);
    base = done_cnt;
    push_exp(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 8, 2'b00, 1'b0, 1, 1'b1);
    send_bit(1'b1);
    chk("t6_done", done_cnt - base, 1);
    chk("t6_break", int'(break_flag), 0);
    chk("t6_overrun", int'(overrun_flag), 0);
    read_chk("t6");
    chk("t6_only", int'(fifo_empty), 1);
    chk("t6_sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
